// File: rtl/bpf_pkg.sv
// Shared definitions for the BPF datapath: default register geometry,
// the register-select type and the register-file sequencing states.
package bpf_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int NREGS_DEF = 4;
  localparam int SELW_DEF  = $clog2(NREGS_DEF);

  typedef logic [SELW_DEF-1:0] sel_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } rf_state_e;

endpackage

// File: rtl/bpf_regfile.sv
// Register bank for the BPF operand mux: live packed view of all registers,
// a registered two-operand read port with write bypass, and a sequenced clear.
module bpf_regfile
  import bpf_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NREGS = NREGS_DEF,
  localparam int SELW = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [SELW-1:0]        wr_addr,
  input  logic [WIDTH-1:0]       wr_data,
  output logic                   wr_drop,
  input  logic                   clr_start,
  output logic                   busy,
  input  logic                   rd_valid,
  output logic                   rd_ready,
  input  logic [SELW-1:0]        rd_sel_a,
  input  logic [SELW-1:0]        rd_sel_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_a,
  output logic [WIDTH-1:0]       out_b,
  output logic [NREGS*WIDTH-1:0] regs_flat
);

  localparam logic [SELW-1:0] LAST_IDX = SELW'(NREGS - 1);

  rf_state_e        state_q, state_d;
  logic [SELW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic             wr_drop_q, wr_drop_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_a_q, out_a_d;
  logic [WIDTH-1:0] out_b_q, out_b_d;

  logic             busy_s;
  logic             rd_ready_s;
  logic             rd_accept_s;
  logic             wr_accept_s;

  assign busy_s      = (state_q == ST_CLEAR);
  assign rd_ready_s  = !busy_s && (!out_valid_q || out_ready);
  assign rd_accept_s = rd_valid && rd_ready_s;
  assign wr_accept_s = wr_en && !busy_s;

  // Storage update and clear sequencing
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    regs_d  = regs_q;
    case (state_q)
      ST_IDLE: begin
        if (wr_accept_s) begin
          regs_d[wr_addr] = wr_data;
        end else begin
          regs_d[wr_addr] = regs_q[wr_addr];
        end
        if (clr_start) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
          cnt_d   = cnt_q;
        end
      end
      ST_CLEAR: begin
        // clr_start is deliberately not examined here: no restart mid-sweep
        regs_d[cnt_q] = '0;
        cnt_d         = cnt_q + SELW'(1);
        if (cnt_q == LAST_IDX) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_CLEAR;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Operand stage: snapshot on accept, with same-cycle write forwarded
  always_comb begin
    out_valid_d = out_valid_q;
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;
    wr_drop_d   = wr_en && busy_s;
    if (rd_accept_s) begin
      out_valid_d = 1'b1;
      if (wr_accept_s && (wr_addr == rd_sel_a)) begin
        out_a_d = wr_data;
      end else begin
        out_a_d = regs_q[rd_sel_a];
      end
      if (wr_accept_s && (wr_addr == rd_sel_b)) begin
        out_b_d = wr_data;
      end else begin
        out_b_d = regs_q[rd_sel_b];
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      wr_drop_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_drop_q   <= wr_drop_d;
      out_valid_q <= out_valid_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_flat
    assign regs_flat[g*WIDTH +: WIDTH] = regs_q[g];
  end

  assign busy      = busy_s;
  assign rd_ready  = rd_ready_s;
  assign wr_drop   = wr_drop_q;
  assign out_valid = out_valid_q;
  assign out_a     = out_a_q;
  assign out_b     = out_b_q;

endmodule

// File: tb/tb_bpf_regfile.sv
// Self-checking bench for bpf_regfile: cycle model plus operand scoreboard.
module tb_bpf_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        wr_drop;
  logic        clr_start;
  logic        busy;
  logic        rd_valid;
  logic        rd_ready;
  logic [1:0]  rd_sel_a;
  logic [1:0]  rd_sel_b;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_a;
  logic [7:0]  out_b;
  logic [31:0] regs_flat;

  int checks   = 0;
  int failures = 0;

  logic [15:0] sb_q [$];
  logic        pop_pend;
  logic [7:0]  m_regs [4];
  logic        m_busy;
  logic [1:0]  m_cnt;
  logic        m_ov;
  logic        m_drop;
  logic [7:0]  m_a;
  logic [7:0]  m_b;

  bpf_regfile #(.WIDTH(8), .NREGS(4)) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_drop(wr_drop),
    .clr_start(clr_start), .busy(busy),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_sel_a(rd_sel_a), .rd_sel_b(rd_sel_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
    .regs_flat(regs_flat)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_flat();
    return {m_regs[3], m_regs[2], m_regs[1], m_regs[0]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
    m_busy = 1'b0; m_cnt = 2'd0; m_ov = 1'b0; m_drop = 1'b0;
    m_a = 8'h00; m_b = 8'h00; pop_pend = 1'b0;
    sb_q.delete();
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; wr_addr = 2'd0; wr_data = 8'h00; clr_start = 1'b0;
    rd_valid = 1'b0; rd_sel_a = 2'd0; rd_sel_b = 2'd0; out_ready = 1'b1;
  endtask

  // Called at a falling edge with inputs already driven; checks, then advances one clock.
  task automatic cycle();
    logic rdy, acc, wacc;
    logic [7:0] ea, eb;
    #1;
    if (pop_pend) begin
      if (sb_q.size() == 0) check_val("sb_empty", 32'd1, 32'd0);
      else {m_a, m_b} = sb_q.pop_front();
      pop_pend = 1'b0;
    end
    rdy  = !m_busy && (!m_ov || out_ready);
    acc  = rd_valid && rdy;
    wacc = wr_en && !m_busy;
    check_val("busy", {31'd0, busy}, {31'd0, m_busy});
    check_val("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
    check_val("rd_ready", {31'd0, rd_ready}, {31'd0, rdy});
    check_val("wr_drop", {31'd0, wr_drop}, {31'd0, m_drop});
    check_val("regs_flat", regs_flat, m_flat());
    check_val("out_a", {24'd0, out_a}, {24'd0, m_a});
    check_val("out_b", {24'd0, out_b}, {24'd0, m_b});
    if (acc) begin
      ea = (wacc && wr_addr == rd_sel_a) ? wr_data : m_regs[rd_sel_a];
      eb = (wacc && wr_addr == rd_sel_b) ? wr_data : m_regs[rd_sel_b];
      sb_q.push_back({ea, eb});
      pop_pend = 1'b1;
    end
    @(posedge clk);
    m_ov   = acc ? 1'b1 : (out_ready ? 1'b0 : m_ov);
    m_drop = wr_en && m_busy;
    if (wacc) m_regs[wr_addr] = wr_data;
    if (m_busy) begin
      m_regs[m_cnt] = 8'h00;
      if (m_cnt == 2'd3) m_busy = 1'b0;
      m_cnt = m_cnt + 2'd1;
    end else if (clr_start) begin
      m_busy = 1'b1;
      m_cnt  = 2'd0;
    end
    @(negedge clk);
  endtask

  task automatic write_reg(input logic [1:0] a, input logic [7:0] d);
    idle_inputs();
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    cycle();
  endtask

  task automatic read_req(input logic [1:0] sa, input logic [1:0] sb);
    idle_inputs();
    rd_valid = 1'b1; rd_sel_a = sa; rd_sel_b = sb;
    cycle();
  endtask

  // Asserts rst between edges and checks outputs clear without waiting for a clock.
  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    check_val("rst_flat", regs_flat, 32'h0);
    check_val("rst_ov", {31'd0, out_valid}, 32'd0);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_ab", {16'd0, out_a, out_b}, 32'd0);
    model_reset();
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int nbusy;
    idle_inputs();
    model_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cycle();

    // Reset asserted mid-run
    write_reg(2'd0, 8'hA5);
    read_req(2'd0, 2'd0);
    async_reset();
    cycle();

    // Basic write then read
    write_reg(2'd1, 8'h5A);
    write_reg(2'd2, 8'hC3);
    read_req(2'd1, 2'd2);
    check_val("rw_ab", {16'd0, out_a, out_b}, {16'd0, 8'h5A, 8'hC3});
    check_val("rw_ov", {31'd0, out_valid}, 32'd1);

    // Bypass on a same-cycle write with identical selects
    write_reg(2'd3, 8'h11);
    idle_inputs();
    wr_en = 1'b1; wr_addr = 2'd3; wr_data = 8'h77;
    rd_valid = 1'b1; rd_sel_a = 2'd3; rd_sel_b = 2'd3;
    cycle();
    check_val("byp_ab", {16'd0, out_a, out_b}, {16'd0, 8'h77, 8'h77});
    check_val("byp_flat", {24'd0, regs_flat[31:24]}, 32'h77);

    // Backpressure holds the snapshot
    read_req(2'd1, 2'd2);
    idle_inputs();
    out_ready = 1'b0; rd_valid = 1'b1; rd_sel_a = 2'd1;
    wr_en = 1'b1; wr_addr = 2'd1; wr_data = 8'hFF;
    #1;
    check_val("bp_rdy", {31'd0, rd_ready}, 32'd0);
    cycle();
    check_val("bp_hold", {24'd0, out_a}, 32'h5A);
    idle_inputs();
    cycle();
    check_val("bp_drain", {31'd0, out_valid}, 32'd0);

    // Clear sequence with dropped write and ignored restart
    write_reg(2'd0, 8'h01);
    write_reg(2'd1, 8'h02);
    write_reg(2'd2, 8'h03);
    write_reg(2'd3, 8'h04);
    idle_inputs();
    clr_start = 1'b1;
    cycle();
    nbusy = 0;
    for (int i = 0; i < 10; i++) begin
      idle_inputs();
      if (i == 1) begin wr_en = 1'b1; wr_addr = 2'd3; wr_data = 8'hEE; end
      if (i == 2) clr_start = 1'b1;
      if (busy !== 1'b1) break;
      nbusy++;
      cycle();
    end
    check_val("clr_len", nbusy, 32'd4);
    check_val("clr_flat", regs_flat, 32'h0);
    idle_inputs();
    cycle();

    // Reset during clear cycle 2
    write_reg(2'd0, 8'h21);
    write_reg(2'd3, 8'h24);
    idle_inputs();
    clr_start = 1'b1;
    cycle();
    idle_inputs();
    cycle();
    async_reset();
    read_req(2'd0, 2'd3);
    check_val("rclr_ab", {16'd0, out_a, out_b}, 32'h0);
    idle_inputs();
    cycle();

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      wr_en     = 1'($urandom_range(0, 1));
      wr_addr   = 2'($urandom_range(0, 3));
      wr_data   = 8'($urandom_range(0, 255));
      clr_start = ($urandom_range(0, 19) == 0);
      rd_valid  = 1'($urandom_range(0, 1));
      rd_sel_a  = 2'($urandom_range(0, 3));
      rd_sel_b  = 2'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    idle_inputs();
    repeat (6) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
